// File: rtl/keccak_pipe_pkg.sv
// Shared helpers for the delay-line pipeline blocks: width computation and
// wrap-aware pointer increment for storage depths that need not be powers of two.
package keccak_pipe_pkg;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Returns to zero after depth-1; for power-of-two depths this matches a plain modulo-2^k count.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == (depth - 32'd1)) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/nbit_dff.sv
// Enabled N-bit register with asynchronous active-low clear; the building
// block of our fixed-latency delay chains and small register files.
module nbit_dff #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Storage register, loaded only when enabled.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_drain_store.sv
// DEPTH x DATA_WIDTH register file for pipe_drain_buffer: one write port,
// one asynchronous read port, every entry cleared by reset.
module pipe_drain_store
    import keccak_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_s [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        nbit_dff #(
            .WIDTH(DATA_WIDTH)
        ) u_entry (
            .clk_i   (clk_i),
            .resetn_i(resetn_i),
            .en_i    (we_i && (waddr_i == AW'(i))),
            .d_i     (wdata_i),
            .q_o     (mem_s[i])
        );
    end

    assign rdata_o = mem_s[raddr_i];

endmodule

// File: rtl/pipe_drain_buffer.sv
// Credit-based terminator for a free-running fixed-latency pipeline: issues
// credits, captures pipeline exits, re-presents them on valid/ready.
// Optional sticky protocol-error flag when PIPE_DRAIN_ERR_EN is defined.
module pipe_drain_buffer
    import keccak_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_CLOCKS   = 12,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         pipe_issue,
    input  logic                         pipe_valid,
    input  logic [DATA_WIDTH-1:0]        pipe_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [clog2(DEPTH+1)-1:0]    level
`ifdef PIPE_DRAIN_ERR_EN
    ,
    output logic                         err
`endif
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push_s;
    logic             pop_s;

    // in_ready depends on flops only, so the producer never sees a comb path from out_ready.
    assign in_ready   = (credit_q != DEPTH_C);
    assign pipe_issue = in_valid & in_ready;
    assign out_valid  = (count_q != CNT_W'(0));
    assign pop_s      = out_valid & out_ready;
    assign push_s     = pipe_valid & (count_q != DEPTH_C);
    assign level      = count_q;

    // Next-state for credits, occupancy and both pointers.
    always_comb begin
        credit_d = credit_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case ({pipe_issue, pop_s})
            2'b10:   credit_d = credit_q + CNT_W'(1);
            2'b01:   credit_d = credit_q - CNT_W'(1);
            default: credit_d = credit_q;
        endcase

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_s) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            credit_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef PIPE_DRAIN_ERR_EN
    logic err_q, err_d;

    // Sticky flag: arrival while full, or a pop with no outstanding credit.
    always_comb begin
        err_d = err_q;
        if ((pipe_valid && (count_q == DEPTH_C)) || (pop_s && (credit_q == CNT_W'(0)))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    pipe_drain_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (PTR_W)
    ) u_store (
        .clk_i   (clk),
        .resetn_i(resetn),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (pipe_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_data)
    );

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Bench for pipe_drain_buffer: a DEPTH=16/N=12 instance under directed traffic
// and a DEPTH=5/N=7 instance under random back-pressure, each against a counting model.
module tb_pipe_drain_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: DEPTH=16, N=12 ----------------
    logic       rstn16, in_valid16, in_ready16, pipe_issue16, pipe_valid16;
    logic       out_valid16, out_ready16, inject16;
    logic [7:0] in_data16, pipe_data16, out_data16;
    logic [4:0] level16;
    logic [11:0] v16;
    logic [7:0]  d16 [12];
`ifdef PIPE_DRAIN_ERR_EN
    logic err16;
`endif

    pipe_drain_buffer #(.DATA_WIDTH(8), .N_CLOCKS(12), .DEPTH(16)) dut16 (
        .clk(clk), .resetn(rstn16), .in_valid(in_valid16), .in_ready(in_ready16),
        .pipe_issue(pipe_issue16), .pipe_valid(pipe_valid16), .pipe_data(pipe_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .level(level16)
`ifdef PIPE_DRAIN_ERR_EN
        , .err(err16)
`endif
    );

    // 12-stage delay line sharing the DUT reset
    always @(posedge clk or negedge rstn16) begin
        if (!rstn16) begin
            v16 <= '0;
            for (int i = 0; i < 12; i++) d16[i] <= 8'd0;
        end else begin
            v16 <= {v16[10:0], pipe_issue16};
            d16[0] <= in_data16;
            for (int i = 1; i < 12; i++) d16[i] <= d16[i-1];
        end
    end
    assign pipe_valid16 = v16[11] | inject16;
    assign pipe_data16  = d16[11];

    // ---------------- instance B: DEPTH=5, N=7 ----------------
    logic       rstn5, in_valid5, in_ready5, pipe_issue5, pipe_valid5;
    logic       out_valid5, out_ready5;
    logic [7:0] in_data5, pipe_data5, out_data5;
    logic [2:0] level5;
    logic [6:0] v5;
    logic [7:0] d5 [7];
`ifdef PIPE_DRAIN_ERR_EN
    logic err5;
`endif

    pipe_drain_buffer #(.DATA_WIDTH(8), .N_CLOCKS(7), .DEPTH(5)) dut5 (
        .clk(clk), .resetn(rstn5), .in_valid(in_valid5), .in_ready(in_ready5),
        .pipe_issue(pipe_issue5), .pipe_valid(pipe_valid5), .pipe_data(pipe_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
        .level(level5)
`ifdef PIPE_DRAIN_ERR_EN
        , .err(err5)
`endif
    );

    always @(posedge clk or negedge rstn5) begin
        if (!rstn5) begin
            v5 <= '0;
            for (int i = 0; i < 7; i++) d5[i] <= 8'd0;
        end else begin
            v5 <= {v5[5:0], pipe_issue5};
            d5[0] <= in_data5;
            for (int i = 1; i < 7; i++) d5[i] <= d5[i-1];
        end
    end
    assign pipe_valid5 = v5[6];
    assign pipe_data5  = d5[6];

    // ---------------- checking helpers and model ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // k-th word sent after reset on instance id
    function automatic logic [7:0] data_of(input int id, input int k);
        if (id == 0) return 8'(k * 37 + 165);
        else         return 8'(k * 13 + 3);
    endfunction

    // Model: credits = stored + in flight; buffer content is words n_pop..n_push-1 in order.
    int credit_m [2];
    int n_push_m [2];
    int n_pop_m  [2];

    task automatic model_cycle(input int id, input int depth, input logic rstn,
                               input logic iv, input logic ordy, input logic pv,
                               input logic irdy, input logic piss, input logic ov,
                               input logic [7:0] od, input int lvl);
        int  stored;
        bit  exp_rdy, iss, pop, push;
        if (!rstn) begin
            credit_m[id] = 0; n_push_m[id] = 0; n_pop_m[id] = 0;
            chk(id == 0 ? "rst_ready16" : "rst_ready5", int'(irdy), 1);
            chk(id == 0 ? "rst_valid16" : "rst_valid5", int'(ov), 0);
            chk(id == 0 ? "rst_level16" : "rst_level5", lvl, 0);
            chk(id == 0 ? "rst_data16" : "rst_data5", int'(od), 0);
        end else begin
            stored  = n_push_m[id] - n_pop_m[id];
            exp_rdy = (credit_m[id] != depth);
            chk(id == 0 ? "in_ready16" : "in_ready5", int'(irdy), int'(exp_rdy));
            chk(id == 0 ? "issue16" : "issue5", int'(piss), int'(iv & exp_rdy));
            chk(id == 0 ? "out_valid16" : "out_valid5", int'(ov), int'(stored != 0));
            chk(id == 0 ? "level16" : "level5", lvl, stored);
            if (stored != 0)
                chk(id == 0 ? "out_data16" : "out_data5", int'(od), int'(data_of(id, n_pop_m[id])));
            iss  = iv & exp_rdy;
            pop  = (stored != 0) & ordy;
            push = pv & (stored < depth);
            credit_m[id] = credit_m[id] + int'(iss) - int'(pop);
            n_push_m[id] = n_push_m[id] + int'(push);
            n_pop_m[id]  = n_pop_m[id] + int'(pop);
        end
    endtask

    // Single compare process for both instances
    always @(negedge clk) begin
        model_cycle(0, 16, rstn16, in_valid16, out_ready16, pipe_valid16, in_ready16,
                    pipe_issue16, out_valid16, out_data16, int'(level16));
        model_cycle(1, 5, rstn5, in_valid5, out_ready5, pipe_valid5, in_ready5,
                    pipe_issue5, out_valid5, out_data5, int'(level5));
    end

    // ---------------- instance A stimulus ----------------
    int sent16 = 0;

    task automatic step16(output bit iss);
        @(negedge clk);
        iss = pipe_issue16;
        @(posedge clk);
        #1;
        if (iss) begin
            sent16++;
            in_data16 = data_of(0, sent16);
        end
    endtask

    bit done5 = 1'b0;

    initial begin
        bit iss;
        int cnt, drops, maxlvl, steps;
        rstn16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b0; inject16 = 1'b0;
        in_data16 = data_of(0, 0);
        #2 rstn16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("p_rst_ready", int'(in_ready16), 1);
        chk("p_rst_valid", int'(out_valid16), 0);
        chk("p_rst_level", int'(level16), 0);
        chk("p_rst_data", int'(out_data16), 0);
        @(posedge clk); #1 rstn16 = 1'b1;

        // single word 0xA5 after 5 idle cycles; visible only N+1 cycles after issue
        out_ready16 = 1'b1;
        for (int i = 0; i < 5; i++) step16(iss);
        chk("p_first_word", int'(in_data16), 8'hA5);
        in_valid16 = 1'b1;
        step16(iss);
        chk("p_single_issue", int'(iss), 1);
        in_valid16 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("p_single_valid", int'(out_valid16), int'(k == 13));
            if (k == 13) chk("p_single_data", int'(out_data16), 8'hA5);
            @(posedge clk); #1;
        end
        chk("p_single_level", int'(level16), 0);

        // back-pressure: exactly DEPTH issues, then credits exhausted
        out_ready16 = 1'b0; in_valid16 = 1'b1; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step16(iss);
            cnt += int'(iss);
        end
        chk("p_fill_issues", cnt, 16);
        chk("p_fill_ready", int'(in_ready16), 0);
        chk("p_fill_level", int'(level16), 16);
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        for (int i = 0; i < 20; i++) step16(iss);
        chk("p_drain_level", int'(level16), 0);

        // full throughput for 100 words
        in_valid16 = 1'b1; cnt = 0; drops = 0; maxlvl = 0; steps = 0;
        while (cnt < 100 && steps < 200) begin
            if (!in_ready16) drops++;
            if (int'(level16) > maxlvl) maxlvl = int'(level16);
            step16(iss);
            cnt += int'(iss);
            steps++;
        end
        in_valid16 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (int'(level16) > maxlvl) maxlvl = int'(level16);
            step16(iss);
        end
        chk("p_thru_steps", steps, 100);
        chk("p_thru_drops", drops, 0);
        chk("p_thru_maxlvl", maxlvl, 1);
        chk("p_thru_empty", int'(level16), 0);

        // reset with 7 words in flight and 4 stored
        out_ready16 = 1'b0; in_valid16 = 1'b1;
        for (int i = 0; i < 11; i++) step16(iss);
        in_valid16 = 1'b0;
        for (int i = 0; i < 30 && level16 != 5'd4; i++) step16(iss);
        chk("p_mid_level", int'(level16), 4);
        chk("p_mid_inflight", $countones(v16), 7);
        rstn16 = 1'b0; sent16 = 0; in_data16 = data_of(0, 0);
        #1;
        chk("p_mid_ready", int'(in_ready16), 1);
        chk("p_mid_valid", int'(out_valid16), 0);
        chk("p_mid_lvl0", int'(level16), 0);
        chk("p_mid_data", int'(out_data16), 0);
        @(posedge clk); #1 rstn16 = 1'b1;
        for (int i = 0; i < 14; i++) step16(iss);
        chk("p_mid_quiet", int'(out_valid16), 0);

`ifdef PIPE_DRAIN_ERR_EN
        chk("p_err_clear", int'(err16), 0);
        out_ready16 = 1'b0; in_valid16 = 1'b1;
        for (int i = 0; i < 40 && in_ready16; i++) step16(iss);
        in_valid16 = 1'b0;
        for (int i = 0; i < 40 && level16 != 5'd16; i++) step16(iss);
        chk("p_err_full", int'(level16), 16);
        chk("p_err_before", int'(err16), 0);
        inject16 = 1'b1;
        step16(iss);
        inject16 = 1'b0;
        chk("p_err_set", int'(err16), 1);
        for (int i = 0; i < 3; i++) step16(iss);
        chk("p_err_hold", int'(err16), 1);
        chk("p_err_level", int'(level16), 16);
        rstn16 = 1'b0; sent16 = 0; in_data16 = data_of(0, 0);
        #1;
        chk("p_err_reset", int'(err16), 0);
        @(posedge clk); #1 rstn16 = 1'b1;
`endif

        for (int i = 0; i < 30000 && !done5; i++) @(posedge clk);
        chk("p_b_done", int'(done5), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- instance B stimulus: 1000 words, random handshakes ----------------
    initial begin
        int  sent5, recv5, cyc;
        bit  iss;
        sent5 = 0; recv5 = 0; cyc = 0;
        rstn5 = 1'b1; in_valid5 = 1'b0; out_ready5 = 1'b0; in_data5 = data_of(1, 0);
        #2 rstn5 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn5 = 1'b1;
        while ((sent5 < 1000 || recv5 < 1000) && cyc < 20000) begin
            in_valid5  = (sent5 < 1000) && ($urandom_range(0, 3) != 0);
            out_ready5 = ($urandom_range(0, 1) == 1) || (sent5 >= 1000);
            @(negedge clk);
            iss = pipe_issue5;
            if (out_valid5 && out_ready5) recv5++;
            @(posedge clk); #1;
            if (iss) begin
                sent5++;
                in_data5 = data_of(1, sent5);
            end
            cyc++;
        end
        in_valid5 = 1'b0;
        chk("b_sent", sent5, 1000);
        chk("b_recv", recv5, 1000);
        chk("b_empty", int'(level5), 0);
        done5 = 1'b1;
    end

endmodule
